cp0_intc: RTL and testbench

Parametrised coprocessor-0 interrupt/exception controller for the single-cycle MIPS core. It replaces the fixed 6-line, two-vector `jump`-mux scheme with N synchronised, edge-latched, maskable interrupt lines and STATUS/CAUSE/EPC registers. It supports an optional vectored mode and `eret` return. It sits beside the datapath: it reads `pc_current`/`pc_next`, serves `mfc0`/`mtc0`, and overrides the next PC through `redir`/`redir_pc`.

---
 rtl/cp0_intc.sv | 176 +++++++++++++++++
 tb/tb_cp0_intc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 interrupt/exception controller (STATUS/CAUSE/EPC, N synchronised edge-latched IRQs).
// Latency: redir/redir_pc/kill/cp0_rd are combinational; an int_in rising edge reaches IP after 3 clk edges.
// Backpressure: none. redir overrides the core's next PC in the same cycle, and mtc0 writes complete every cycle.
//
// Ports:
//   clk, rst                 core clock (rising edge), asynchronous active-low reset
//   int_in[N_INT]            asynchronous level interrupt requests
//   pc_current, pc_next      executing PC and the un-overridden next PC
//   exc_req, exc_code        synchronous exception raised by the current instruction
//   eret                     current instruction is eret
//   we_cp0, cp0_addr, cp0_wd mtc0 write port
//   cp0_rd                   mfc0 read data (combinational)
//   redir, redir_pc          next-PC override
//   kill                     suppress architectural writes of the current instruction
module cp0_intc #(
  parameter int             N_INT       = 6,
  parameter int             W           = 32,
  parameter logic [W-1:0]   EXC_VEC     = 'h180,
  parameter logic [W-1:0]   INT_VEC     = 'h200,
  parameter int             VECTORED    = 0,
  parameter logic [W-1:0]   VEC_SPACING = 'h20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_INT-1:0] int_in,
  input  logic [W-1:0]     pc_current,
  input  logic [W-1:0]     pc_next,
  input  logic             exc_req,
  input  logic [4:0]       exc_code,
  input  logic             eret,
  input  logic             we_cp0,
  input  logic [4:0]       cp0_addr,
  input  logic [W-1:0]     cp0_wd,
  output logic [W-1:0]     cp0_rd,
  output logic             redir,
  output logic [W-1:0]     redir_pc,
  output logic             kill
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  // Synchroniser and edge detector
  logic [N_INT-1:0] s1_q, s2_q, s2d_q;
  logic [N_INT-1:0] rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s2d_q <= '0;
    end else begin
      s1_q  <= int_in;
      s2_q  <= s1_q;
      s2d_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s2d_q;

  // Architectural state
  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [N_INT-1:0] im_q, im_d;
  logic [N_INT-1:0] ip_q, ip_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [W-1:0]     epc_q, epc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      im_q      <= '0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      im_q      <= im_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  // Take decision
  logic [N_INT-1:0] pending;
  logic             int_take;
  logic [W-1:0]     idx_w;

  assign pending  = ip_q & im_q;
  assign int_take = ie_q & ~exl_q & (|pending) & ~exc_req & ~eret;

  // Lowest pending index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    idx_w = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (pending[i]) idx_w = W'(i);
    end
  end

  always_comb begin
    redir    = 1'b0;
    redir_pc = '0;
    kill     = 1'b0;
    if (exc_req) begin
      redir    = 1'b1;
      redir_pc = EXC_VEC;
      kill     = 1'b1;
    end else if (eret) begin
      redir    = 1'b1;
      redir_pc = epc_q;
    end else if (int_take) begin
      redir    = 1'b1;
      redir_pc = (VECTORED != 0) ? (INT_VEC + idx_w * VEC_SPACING) : INT_VEC;
    end
  end

  // Next state: software write first, hardware events override EXL/EPC/ExcCode.
  logic wr_status, wr_cause, wr_epc;
  assign wr_status = we_cp0 && (cp0_addr == ADDR_STATUS);
  assign wr_cause  = we_cp0 && (cp0_addr == ADDR_CAUSE);
  assign wr_epc    = we_cp0 && (cp0_addr == ADDR_EPC);

  always_comb begin
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;

    if (wr_status) begin
      ie_d  = cp0_wd[0];
      exl_d = cp0_wd[1];
      im_d  = cp0_wd[8 +: N_INT];
    end
    if (wr_epc) epc_d = cp0_wd;

    if (exc_req) begin
      exl_d     = 1'b1;
      exccode_d = exc_code;
      // Nested exceptions keep the original return address.
      if (!exl_q) epc_d = pc_current;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (int_take) begin
      exl_d     = 1'b1;
      exccode_d = '0;
      epc_d     = pc_next;
    end

    // Write-1-to-clear, with a new edge taking precedence over a clear.
    ip_d = (ip_q & ~(wr_cause ? cp0_wd[8 +: N_INT] : {N_INT{1'b0}})) | rise;
  end

  // mfc0 read mux
  always_comb begin
    cp0_rd = '0;
    unique case (cp0_addr)
      ADDR_STATUS: begin
        cp0_rd[0]          = ie_q;
        cp0_rd[1]          = exl_q;
        cp0_rd[8 +: N_INT] = im_q;
      end
      ADDR_CAUSE: begin
        cp0_rd[6:2]        = exccode_q;
        cp0_rd[8 +: N_INT] = ip_q;
      end
      ADDR_EPC: cp0_rd = epc_q;
      default:  cp0_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: one vectored and one flat instance share stimulus.
// Expected values are pushed to a scoreboard queue, then popped and compared on the sampled output.
`timescale 1ns/10ps
module tb_cp0_intc;

  logic        clk;
  logic        rst;
  logic [5:0]  int_in;
  logic [31:0] pc_current, pc_next;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic        we_cp0;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wd;

  logic [31:0] cp0_rd, redir_pc;
  logic        redir, kill;
  logic [31:0] cp0_rd_f, redir_pc_f;
  logic        redir_f, kill_f;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  cp0_intc #(.N_INT(6), .W(32), .EXC_VEC(32'h180), .INT_VEC(32'h200),
             .VECTORED(1), .VEC_SPACING(32'h20)) u_vec (
    .clk(clk), .rst(rst), .int_in(int_in), .pc_current(pc_current), .pc_next(pc_next),
    .exc_req(exc_req), .exc_code(exc_code), .eret(eret), .we_cp0(we_cp0),
    .cp0_addr(cp0_addr), .cp0_wd(cp0_wd), .cp0_rd(cp0_rd), .redir(redir),
    .redir_pc(redir_pc), .kill(kill)
  );

  cp0_intc #(.N_INT(6), .W(32), .EXC_VEC(32'h180), .INT_VEC(32'h200),
             .VECTORED(0), .VEC_SPACING(32'h20)) u_flat (
    .clk(clk), .rst(rst), .int_in(int_in), .pc_current(pc_current), .pc_next(pc_next),
    .exc_req(exc_req), .exc_code(exc_code), .eret(eret), .we_cp0(we_cp0),
    .cp0_addr(cp0_addr), .cp0_wd(cp0_wd), .cp0_rd(cp0_rd_f), .redir(redir_f),
    .redir_pc(redir_pc_f), .kill(kill_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic settle();
    #0.1;
  endtask

  // Advance past one rising edge and land well clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] exp_v);
    push_exp(tag, exp_v);
    settle();
    case (tag.substr(0, 1))
      "rd": pop_cmp(redir_pc);
      "rf": pop_cmp(redir_pc_f);
      "rv": pop_cmp({31'd0, redir});
      "kl": pop_cmp({31'd0, kill});
      default: pop_cmp(32'hDEAD_BEEF);
    endcase
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp_v);
    cp0_addr = a;
    push_exp(tag, exp_v);
    settle();
    pop_cmp(cp0_rd);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_addr = a;
    cp0_wd   = d;
    we_cp0   = 1'b1;
    step();
    we_cp0   = 1'b0;
    cp0_wd   = '0;
  endtask

  initial begin
    rst = 1'b0; int_in = '0; pc_current = 32'h0040_0004; pc_next = 32'h0040_0008;
    exc_req = 1'b0; exc_code = '0; eret = 1'b0; we_cp0 = 1'b0; cp0_addr = '0; cp0_wd = '0;
    #3;
    // Reset state
    chk("rv_reset", 32'd0);
    chk("rd_reset_pc", 32'd0);
    chk("kl_reset", 32'd0);
    rd("status_reset", 5'd12, 32'd0);
    rd("cause_reset", 5'd13, 32'd0);
    rd("epc_reset", 5'd14, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Single-cycle pulse on line 0: IP0 appears after the third edge.
    wr(5'd12, 32'h0000_0101);
    int_in = 6'b000001;
    step();
    int_in = '0;
    chk("rv_after_e1", 32'd0);
    step();
    chk("rv_after_e2", 32'd0);
    rd("cause_after_e2", 5'd13, 32'd0);
    step();
    chk("rv_after_e3", 32'd1);
    chk("rd_int0_vec", 32'h200);
    chk("rf_int0_flat", 32'h200);
    chk("kl_int_take", 32'd0);
    rd("cause_ip0", 5'd13, 32'h100);
    step();
    rd("epc_int0", 5'd14, 32'h0040_0008);
    rd("status_exl", 5'd12, 32'h103);
    chk("rv_exl_masks", 32'd0);

    // Clear IP0 and return.
    wr(5'd13, 32'h100);
    rd("cause_w1c0", 5'd13, 32'd0);
    eret = 1'b1;
    chk("rv_eret", 32'd1);
    chk("rd_eret_epc", 32'h0040_0008);
    chk("kl_eret", 32'd0);
    step();
    eret = 1'b0;
    rd("status_after_eret", 5'd12, 32'h101);
    chk("rv_idle", 32'd0);

    // Lines 3 and 5 together: lowest index wins in vectored mode.
    wr(5'd12, 32'h0000_2901);
    int_in = 6'b101000;
    step(); step(); step();
    chk("rv_int35", 32'd1);
    chk("rd_int3_vec", 32'h260);
    chk("rf_int3_flat", 32'h200);
    rd("cause_ip35", 5'd13, 32'h2800);
    wr(5'd13, 32'h800);
    rd("cause_ip3_cleared", 5'd13, 32'h2000);
    rd("status_exl2", 5'd12, 32'h2903);
    rd("epc_int3", 5'd14, 32'h0040_0008);
    chk("rv_exl2", 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("rv_post_eret", 32'd1);
    chk("rd_int5_vec", 32'h2A0);
    rd("status_eret2", 5'd12, 32'h2901);
    step();
    rd("status_take5", 5'd12, 32'h2903);
    int_in = '0;
    wr(5'd13, 32'h2000);
    rd("cause_single_set", 5'd13, 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("rv_nothing_pending", 32'd0);

    // Exception outranks a pending interrupt; nested exception keeps EPC.
    int_in = 6'b000001;
    step();
    int_in = '0;
    step(); step();
    chk("rd_pending_int0", 32'h200);
    pc_current = 32'h0040_0020;
    exc_req = 1'b1;
    exc_code = 5'd12;
    chk("rd_exc_vec", 32'h180);
    chk("kl_exc", 32'd1);
    chk("rv_exc", 32'd1);
    step();
    exc_req = 1'b0;
    rd("epc_exc", 5'd14, 32'h0040_0020);
    rd("cause_exc12", 5'd13, 32'h130);
    rd("status_exc", 5'd12, 32'h2903);
    pc_current = 32'h0040_0030;
    exc_req = 1'b1;
    exc_code = 5'd4;
    chk("rd_nested_vec", 32'h180);
    step();
    exc_req = 1'b0;
    pc_current = 32'h0040_0004;
    rd("epc_nested_kept", 5'd14, 32'h0040_0020);
    rd("cause_exc4", 5'd13, 32'h110);

    // eret with a pending interrupt: interrupt waits one cycle.
    wr(5'd14, 32'h0040_0010);
    rd("epc_mtc0", 5'd14, 32'h0040_0010);
    eret = 1'b1;
    chk("rd_eret_pending", 32'h0040_0010);
    chk("kl_eret_pending", 32'd0);
    step();
    eret = 1'b0;
    rd("status_eret3", 5'd12, 32'h2901);
    chk("rv_take_after_eret", 32'd1);
    chk("rd_take_after_eret", 32'h200);
    // mtc0 STATUS with EXL=0 on the take edge: hardware sets EXL anyway.
    wr(5'd12, 32'h0000_2901);
    rd("status_hw_wins", 5'd12, 32'h2903);
    rd("epc_take_next", 5'd14, 32'h0040_0008);
    rd("cause_code0", 5'd13, 32'h100);
    wr(5'd13, 32'h100);
    rd("cause_clr0", 5'd13, 32'd0);

    // Clear of IP2 on the same edge as its new rising edge: set wins.
    int_in = 6'b000100;
    step();
    int_in = '0;
    step();
    wr(5'd13, 32'h400);
    rd("cause_set_wins", 5'd13, 32'h400);

    // Reset mid-handler (EXL=1, IP2 pending).
    rst = 1'b0;
    rd("status_midrst", 5'd12, 32'd0);
    rd("cause_midrst", 5'd13, 32'd0);
    rd("epc_midrst", 5'd14, 32'd0);
    chk("rv_midrst", 32'd0);
    step();
    rst = 1'b1;
    step();

    // Unmapped register ignores writes and reads zero.
    wr(5'd5, 32'hFFFF_FFFF);
    rd("unmapped", 5'd5, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
